// File: rtl/modem_deframer_if.sv
// Bit-stream input and byte-stream output bundle of the modem receive deframer.
// master = demodulator/consumer side, slave = deframer.
interface modem_deframer_if;
  logic        bit_i;
  logic        bit_valid_i;
  logic [7:0]  rx_byte_o;
  logic        rx_byte_valid_o;
  logic        rx_begin_o;
  logic        rx_end_o;
  logic        frame_ok_o;
  logic        busy_o;
  logic [15:0] crc_err_cnt_o;
  logic [15:0] frame_cnt_o;

  modport master (
    output bit_i, bit_valid_i,
    input  rx_byte_o, rx_byte_valid_o, rx_begin_o, rx_end_o, frame_ok_o, busy_o,
           crc_err_cnt_o, frame_cnt_o
  );

  modport slave (
    input  bit_i, bit_valid_i,
    output rx_byte_o, rx_byte_valid_o, rx_begin_o, rx_end_o, frame_ok_o, busy_o,
           crc_err_cnt_o, frame_cnt_o
  );
endinterface

// File: rtl/modem_deframer.sv
// Serial receive deframer: hunts for the sync word, then parses LEN, payload and CRC-16
// and emits begin/byte/end pulses for the RX ring-buffer controller.
module modem_deframer #(
  parameter logic [15:0] SYNC_WORD = 16'h2DD4,
  parameter int unsigned MAX_LEN   = 1020,
  parameter int unsigned TIMEOUT   = 4096
) (
  input logic             clk,
  input logic             rst,
  modem_deframer_if.slave rx_if
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StHunt, StLen, StPayload, StCrc} state_e;

  state_e           state_q, state_d;
  logic [15:0]      sync_q, sync_d;
  logic [15:0]      crc_q, crc_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      len_sr_q, len_sr_d;
  logic [9:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_sr_q, byte_sr_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic             rx_begin_q, rx_begin_d;
  logic             rx_end_q, rx_end_d;
  logic             frame_ok_q, frame_ok_d;
  logic             busy_q, busy_d;
  logic [15:0]      crc_err_cnt_q, crc_err_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic        bit_in, bit_v;
  logic [15:0] crc_step, sync_shift, len_full;
  logic [7:0]  byte_full;
  logic        len_bad, timeout, abort;

  assign bit_in = rx_if.bit_i;
  assign bit_v  = rx_if.bit_valid_i;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    crc_step   = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? 16'h1021 : 16'h0000);
    sync_shift = {sync_q[14:0], bit_in};
    len_full   = {bit_in, len_sr_q[15:1]};
    byte_full  = {bit_in, byte_sr_q[7:1]};
    len_bad    = (len_full == 16'd0) || (len_full[15:10] != 6'd0) ||
                 (len_full[9:0] > 10'(MAX_LEN));
    timeout    = !bit_v && (idle_q == IdleW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d         = state_q;
    sync_d          = sync_q;
    crc_d           = crc_q;
    bit_cnt_d       = bit_cnt_q;
    len_sr_d        = len_sr_q;
    byte_cnt_d      = byte_cnt_q;
    byte_sr_d       = byte_sr_q;
    idle_d          = '0;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    rx_begin_d      = 1'b0;
    rx_end_d        = 1'b0;
    frame_ok_d      = frame_ok_q;
    crc_err_cnt_d   = crc_err_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    abort           = 1'b0;

    if (state_q != StHunt && !bit_v) begin
      idle_d = idle_q + IdleW'(1);
    end

    unique case (state_q)
      StHunt: begin
        if (bit_v) begin
          sync_d = sync_shift;
          if (sync_shift == SYNC_WORD) begin
            // Clearing the sync register here keeps frame bits from ever re-arming sync.
            state_d   = StLen;
            sync_d    = '0;
            crc_d     = 16'hFFFF;
            bit_cnt_d = '0;
          end
        end
      end
      StLen: begin
        if (bit_v) begin
          crc_d     = crc_step;
          len_sr_d  = len_full;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            if (len_bad) begin
              state_d = StHunt;
            end else begin
              rx_begin_d = 1'b1;
              byte_cnt_d = len_full[9:0];
              bit_cnt_d  = '0;
              state_d    = StPayload;
            end
          end
        end else if (timeout) begin
          state_d = StHunt;
        end
      end
      StPayload: begin
        if (bit_v) begin
          crc_d     = crc_step;
          byte_sr_d = byte_full;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rx_byte_d       = byte_full;
            rx_byte_valid_d = 1'b1;
            bit_cnt_d       = '0;
            byte_cnt_d      = byte_cnt_q - 10'd1;
            if (byte_cnt_q == 10'd1) begin
              state_d = StCrc;
            end
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      StCrc: begin
        if (bit_v) begin
          crc_d     = crc_step;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            rx_end_d   = 1'b1;
            frame_ok_d = (crc_step == 16'h0000);
            if (crc_step == 16'h0000) begin
              frame_cnt_d = sat_inc(frame_cnt_q);
            end else begin
              crc_err_cnt_d = sat_inc(crc_err_cnt_q);
            end
            state_d = StHunt;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase

    if (abort) begin
      rx_end_d      = 1'b1;
      frame_ok_d    = 1'b0;
      crc_err_cnt_d = sat_inc(crc_err_cnt_q);
      state_d       = StHunt;
    end

    // Busy stays up through the rx_end_o cycle so the clock request covers the end pulse.
    busy_d = (state_d != StHunt) || rx_end_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StHunt;
      sync_q          <= '0;
      crc_q           <= 16'hFFFF;
      bit_cnt_q       <= '0;
      len_sr_q        <= '0;
      byte_cnt_q      <= '0;
      byte_sr_q       <= '0;
      idle_q          <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      rx_begin_q      <= 1'b0;
      rx_end_q        <= 1'b0;
      frame_ok_q      <= 1'b0;
      busy_q          <= 1'b0;
      crc_err_cnt_q   <= '0;
      frame_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      crc_q           <= crc_d;
      bit_cnt_q       <= bit_cnt_d;
      len_sr_q        <= len_sr_d;
      byte_cnt_q      <= byte_cnt_d;
      byte_sr_q       <= byte_sr_d;
      idle_q          <= idle_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_begin_q      <= rx_begin_d;
      rx_end_q        <= rx_end_d;
      frame_ok_q      <= frame_ok_d;
      busy_q          <= busy_d;
      crc_err_cnt_q   <= crc_err_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign rx_if.rx_byte_o       = rx_byte_q;
  assign rx_if.rx_byte_valid_o = rx_byte_valid_q;
  assign rx_if.rx_begin_o      = rx_begin_q;
  assign rx_if.rx_end_o        = rx_end_q;
  assign rx_if.frame_ok_o      = frame_ok_q;
  assign rx_if.busy_o          = busy_q;
  assign rx_if.crc_err_cnt_o   = crc_err_cnt_q;
  assign rx_if.frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_modem_deframer.sv
// Directed + randomized bench for modem_deframer: frames are built as bit lists with the
// expected event at each strobe, derived from the wire format rather than the RTL.
module tb_modem_deframer;

  localparam int MaxLen  = 1020;
  localparam int Timeout = 4096;
  localparam int EvNone  = 0;
  localparam int EvBegin = 1;
  localparam int EvByte  = 2;
  localparam int EvEnd   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  modem_deframer_if bus ();

  modem_deframer dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_err     = 0;
  int exp_frame = 0;
  int exp_err   = 0;

  logic       bq[$];
  int         eq[$];
  logic [7:0] vq[$];
  logic [7:0] pay[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte"},   32'(bus.rx_byte_o), 32'd0);
    check({tag, "_valid"},  32'(bus.rx_byte_valid_o), 32'd0);
    check({tag, "_begin"},  32'(bus.rx_begin_o), 32'd0);
    check({tag, "_end"},    32'(bus.rx_end_o), 32'd0);
    check({tag, "_ok"},     32'(bus.frame_ok_o), 32'd0);
    check({tag, "_busy"},   32'(bus.busy_o), 32'd0);
    check({tag, "_errcnt"}, 32'(bus.crc_err_cnt_o), 32'd0);
    check({tag, "_frmcnt"}, 32'(bus.frame_cnt_o), 32'd0);
  endtask

  task automatic add_bit(input logic b, input int e, input logic [7:0] v);
    bq.push_back(b);
    eq.push_back(e);
    vq.push_back(v);
  endtask

  // Append one frame to the bit list; flip_byte >= 0 flips bit 0 of that payload byte
  // after the CRC has been computed over the original payload.
  task automatic build_frame(input bit preamble, input int len_field, input int flip_byte);
    logic        cov[$];
    logic [15:0] c;
    logic [15:0] lv;
    logic [15:0] pre;
    logic [15:0] sw;
    logic [7:0]  sent;
    logic [7:0]  orig;
    bit          legal;
    cov = {};
    pre = 16'hAAAA;
    sw  = 16'h2DD4;
    if (preamble) begin
      repeat (8) add_bit(1'b1, EvNone, 8'd0);
      for (int i = 15; i >= 0; i--) add_bit(pre[i], EvNone, 8'd0);
    end
    for (int i = 15; i >= 0; i--) add_bit(sw[i], EvNone, 8'd0);
    lv    = len_field[15:0];
    legal = (lv != 16'd0) && (int'(lv) <= MaxLen);
    for (int i = 0; i < 16; i++) begin
      add_bit(lv[i], (i == 15 && legal) ? EvBegin : EvNone, 8'd0);
      cov.push_back(lv[i]);
    end
    if (legal) begin
      for (int k = 0; k < int'(lv); k++) begin
        orig = pay[k];
        sent = orig;
        if (k == flip_byte) sent[0] = ~sent[0];
        for (int i = 0; i < 8; i++) begin
          add_bit(sent[i], (i == 7) ? EvByte : EvNone, sent);
          cov.push_back(orig[i]);
        end
      end
      c = 16'hFFFF;
      foreach (cov[j]) c = {c[14:0], 1'b0} ^ ((c[15] ^ cov[j]) ? 16'h1021 : 16'h0000);
      for (int i = 15; i >= 0; i--) begin
        add_bit(c[i], (i == 0) ? EvEnd : EvNone, {7'd0, flip_byte < 0});
      end
    end
  endtask

  // Strobe up to n queued bits; outputs are sampled #1 after each edge.
  task automatic play(input int n, input bit rnd_gap);
    logic       b;
    int         e;
    logic [7:0] v;
    int         gap;
    for (int s = 0; s < n && bq.size() > 0; s++) begin
      b = bq.pop_front();
      e = eq.pop_front();
      v = vq.pop_front();
      bus.bit_i       = b;
      bus.bit_valid_i = 1'b1;
      @(posedge clk);
      #1;
      if (e == EvEnd) begin
        if (v[0]) exp_frame++;
        else exp_err++;
      end
      check("begin_pulse", 32'(bus.rx_begin_o), 32'(e == EvBegin));
      check("byte_valid", 32'(bus.rx_byte_valid_o), 32'(e == EvByte));
      check("end_pulse", 32'(bus.rx_end_o), 32'(e == EvEnd));
      if (e == EvByte) check("byte_value", 32'(bus.rx_byte_o), 32'(v));
      if (e == EvEnd) begin
        check("frame_ok", 32'(bus.frame_ok_o), 32'(v[0]));
        check("frame_cnt", 32'(bus.frame_cnt_o), 32'(exp_frame));
        check("err_cnt", 32'(bus.crc_err_cnt_o), 32'(exp_err));
        check("busy_at_end", 32'(bus.busy_o), 32'd1);
      end
      bus.bit_valid_i = 1'b0;
      gap = rnd_gap ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
        check("quiet_gap", {29'd0, bus.rx_begin_o, bus.rx_byte_valid_o, bus.rx_end_o}, 32'd0);
      end
    end
  endtask

  task automatic rand_payload(input int n);
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    int  waited;
    bit  seen;
    bus.bit_i       = 1'b0;
    bus.bit_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good "abc" frame, then the same frame with bit 0 of the second byte flipped.
    pay = {8'h61, 8'h62, 8'h63};
    build_frame(1'b1, 3, -1);
    play(bq.size(), 1'b1);
    pay = {8'h61, 8'h62, 8'h63};
    build_frame(1'b1, 3, 1);
    play(bq.size(), 1'b1);

    // Illegal lengths: no pulses, back to hunting, then a LEN=1 frame is accepted.
    build_frame(1'b1, 0, -1);
    play(bq.size(), 1'b1);
    build_frame(1'b1, 1021, -1);
    play(bq.size(), 1'b1);
    build_frame(1'b1, 16'h0403, -1);
    play(bq.size(), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("illegal_len_busy", 32'(bus.busy_o), 32'd0);
    rand_payload(1);
    build_frame(1'b1, 1, -1);
    play(bq.size(), 1'b1);

    // Maximum length with back-to-back strobes.
    rand_payload(MaxLen);
    build_frame(1'b1, MaxLen, -1);
    play(bq.size(), 1'b0);
    @(posedge clk);
    #1;
    check("max_len_busy_after_end", 32'(bus.busy_o), 32'd0);

    // Timeout after 5 payload bytes of a LEN=10 frame.
    rand_payload(10);
    build_frame(1'b1, 10, -1);
    play(8 + 16 + 16 + 16 + 40, 1'b0);
    bq.delete();
    eq.delete();
    vq.delete();
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < Timeout + 20) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.rx_end_o) seen = 1'b1;
    end
    if (seen) exp_err++;
    check("timeout_end_seen", 32'(seen), 32'd1);
    check("timeout_latency", 32'(waited >= Timeout - 1 && waited <= Timeout + 1), 32'd1);
    check("timeout_ok", 32'(bus.frame_ok_o), 32'd0);
    check("timeout_err_cnt", 32'(bus.crc_err_cnt_o), 32'(exp_err));
    check("timeout_frame_cnt", 32'(bus.frame_cnt_o), 32'(exp_frame));
    rand_payload(4);
    build_frame(1'b1, 4, -1);
    play(bq.size(), 1'b1);

    // Reset in the middle of a payload.
    rand_payload(6);
    build_frame(1'b1, 6, -1);
    play(8 + 16 + 16 + 16 + 20, 1'b1);
    bq.delete();
    eq.delete();
    vq.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_frame = 0;
    exp_err   = 0;
    check_all_zero("mid_reset");
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.rx_end_o || bus.busy_o) seen = 1'b1;
    end
    check("no_end_after_reset", 32'(seen), 32'd0);

    // Back-to-back frames; the first carries the sync word inside its payload.
    pay = {8'hB4, 8'h2B, 8'($urandom), 8'hB4, 8'h2B};
    build_frame(1'b1, 5, -1);
    rand_payload(7);
    build_frame(1'b0, 7, -1);
    play(bq.size(), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
